// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: copies one 256-byte CPU page to the sprite RAM data port
// (16'h2004), stalling the CPU for the duration and passing the bus through when idle.
module oam_dma_ctrl #(
  parameter int          READ_WAIT = 0,
  parameter logic [15:0] DMA_REG   = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_out,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ALIGN   = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;

  localparam logic [15:0] OAM_DATA = 16'h2004;
  localparam int          WAIT_M1  = (READ_WAIT > 0) ? READ_WAIT - 1 : 0;
  localparam logic [1:0]  WAIT_LD  = WAIT_M1[1:0];
  localparam bit          NO_WAIT  = (READ_WAIT == 0);

  logic [2:0] state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] buffer;
  logic [1:0] wcnt;

  logic trigger;
  logic rd_last;

  assign trigger = (state == S_IDLE) && cpu_write_en && (cpu_addr == DMA_REG);
  // Read data is sampled on the last cycle the read address is still presented.
  assign rd_last = ((state == S_RD) && NO_WAIT) ||
                   ((state == S_RD_WAIT) && (wcnt == 2'd0));
  assign dma_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      page      <= 8'h00;
      idx       <= 8'h00;
      wcnt      <= 2'd0;
      cpu_stall <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        S_IDLE: if (trigger) begin
          page      <= cpu_data_in;
          idx       <= 8'h00;
          state     <= S_ALIGN;
          cpu_stall <= 1'b1;
        end
        S_ALIGN: state <= S_RD;
        S_RD: if (NO_WAIT) begin
          state <= S_WR;
        end else begin
          state <= S_RD_WAIT;
          wcnt  <= WAIT_LD;
        end
        S_RD_WAIT: if (wcnt == 2'd0) state <= S_WR;
                   else              wcnt  <= wcnt - 2'd1;
        S_WR: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state     <= S_IDLE;
            cpu_stall <= 1'b0;
            dma_done  <= 1'b1;
          end else begin
            state <= S_RD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         buffer <= 8'h00;
    else if (rd_last) buffer <= mem_data_out;
  end

  // Idle is a pure combinational passthrough; the trigger write itself never reaches memory.
  always_comb begin
    cpu_data_out = 8'h00;
    mem_addr     = {page, idx};
    mem_data_in  = 8'h00;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state)
      S_IDLE: begin
        cpu_data_out = mem_data_out;
        mem_addr     = cpu_addr;
        mem_data_in  = cpu_data_in;
        mem_write_en = cpu_write_en && (cpu_addr != DMA_REG);
        mem_read_en  = cpu_read_en;
      end
      S_RD: mem_read_en = 1'b1;
      S_WR: begin
        mem_addr     = OAM_DATA;
        mem_data_in  = buffer;
        mem_write_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: READ_WAIT=0 and READ_WAIT=2 instances share CPU stimulus and
// a byte-array memory; transfers are checked against the page contents and stall formula.
module tb_oam_dma_ctrl;

  localparam logic [15:0] DMA_REG = 16'h4014;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;

  logic [7:0]  cdo0, cdo1, mdi0, mdi1, mdo0, mdo1;
  logic [15:0] ma0, ma1;
  logic        stall0, stall1, mwe0, mwe1, mre0, mre1, busy0, busy1, done0, done1;

  logic [7:0] mem [0:65535];
  assign mdo0 = mem[ma0];
  assign mdo1 = mem[ma1];

  always #5 clk = ~clk;

  oam_dma_ctrl #(.READ_WAIT(0), .DMA_REG(DMA_REG)) u_dut0 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_data_out(cdo0),
    .cpu_stall(stall0), .mem_addr(ma0), .mem_data_in(mdi0), .mem_write_en(mwe0),
    .mem_read_en(mre0), .mem_data_out(mdo0), .dma_busy(busy0), .dma_done(done0));

  oam_dma_ctrl #(.READ_WAIT(2), .DMA_REG(DMA_REG)) u_dut1 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_data_out(cdo1),
    .cpu_stall(stall1), .mem_addr(ma1), .mem_data_in(mdi1), .mem_write_en(mwe1),
    .mem_read_en(mre1), .mem_data_out(mdo1), .dma_busy(busy1), .dma_done(done1));

  // Observation only: sprite writes, stall/done cycle counts, last DMA read address.
  logic [7:0]  q0[$], q1[$];
  int          stall_n0 = 0, stall_n1 = 0, done_n0 = 0, done_n1 = 0, viol0 = 0, viol1 = 0;
  logic [15:0] last_rd0 = 16'h0, last_rd1 = 16'h0;

  always @(negedge clk) begin
    if (busy0 && mwe0 && ma0 == 16'h2004) q0.push_back(mdi0);
    if (busy1 && mwe1 && ma1 == 16'h2004) q1.push_back(mdi1);
    if (stall0) stall_n0++;
    if (stall1) stall_n1++;
    if (done0) done_n0++;
    if (done1) done_n1++;
    if (done0 && stall0) viol0++;
    if (done1 && stall1) viol1++;
    if (busy0 && mre0) last_rd0 = ma0;
    if (busy1 && mre1) last_rd1 = ma1;
  end

  int checks = 0;
  int failures = 0;
  int qb0, qb1, sb0, sb1, db0, db1, vb0, vb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    qb0 = q0.size(); qb1 = q1.size();
    sb0 = stall_n0;  sb1 = stall_n1;
    db0 = done_n0;   db1 = done_n1;
    vb0 = viol0;     vb1 = viol1;
  endtask

  task automatic start_dma(input logic [7:0] pg);
    snap();
    cpu_addr = DMA_REG; cpu_data_in = pg; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    #1;
    chk("trigger_write_suppressed", {31'd0, mwe0}, 32'd0);
    tick();
    cpu_write_en = 1'b0;
    cpu_addr = 16'h1234;
    chk("busy_after_trigger", {30'd0, busy1, busy0}, 32'd3);
    chk("stall_after_trigger", {30'd0, stall1, stall0}, 32'd3);
  endtask

  task automatic wait_done();
    int c = 0;
    while (c < 4000 && !((done_n0 > db0) && (done_n1 > db1))) begin
      tick();
      c++;
    end
    chk("done_within_bound", {31'd0, c < 4000}, 32'd1);
    repeat (4) tick();
  endtask

  // Reference: one write per byte of the page, in address order; stall 1+256*(2+wait).
  task automatic check_dma(input logic [7:0] pg);
    int mm0 = 0, mm1 = 0;
    chk("writes_rw0", q0.size() - qb0, 256);
    chk("writes_rw2", q1.size() - qb1, 256);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = {pg, 8'(i)};
      if (qb0 + i < q0.size() && q0[qb0 + i] !== mem[a]) mm0++;
      if (qb1 + i < q1.size() && q1[qb1 + i] !== mem[a]) mm1++;
    end
    chk("data_rw0", mm0, 0);
    chk("data_rw2", mm1, 0);
    chk("stall_rw0", stall_n0 - sb0, 1 + 256 * (2 + 0));
    chk("stall_rw2", stall_n1 - sb1, 1 + 256 * (2 + 2));
    chk("done_pulses_rw0", done_n0 - db0, 1);
    chk("done_pulses_rw2", done_n1 - db1, 1);
    chk("stall_low_with_done", (viol0 - vb0) + (viol1 - vb1), 0);
    chk("idle_after_dma", {30'd0, busy1, busy0}, 32'd0);
  endtask

  initial begin
    int c;
    int s0, s1;
    logic [15:0] ra;
    logic [7:0]  rpg;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    rst = 1'b0; cpu_addr = 16'h0; cpu_data_in = 8'h0; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    repeat (2) tick();
    chk("reset_stall", {30'd0, stall1, stall0}, 32'd0);
    chk("reset_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("reset_done", {30'd0, done1, done0}, 32'd0);
    rst = 1'b1;
    tick();

    // Idle read of PPU status passes straight through.
    cpu_addr = 16'h2002; cpu_read_en = 1'b1;
    #1;
    chk("idle_rd_en", {31'd0, mre0}, 32'd1);
    chk("idle_rd_addr", {16'd0, ma0}, {16'd0, 16'h2002});
    chk("idle_rd_data", {24'd0, cdo0}, {24'd0, mem[16'h2002]});
    chk("idle_rd_stall", {31'd0, stall0}, 32'd0);

    // A read of the DMA register is not a trigger.
    cpu_addr = DMA_REG;
    #1;
    chk("dmareg_rd_en", {31'd0, mre0}, 32'd1);
    chk("dmareg_rd_data", {24'd0, cdo0}, {24'd0, mem[DMA_REG]});
    tick();
    chk("dmareg_rd_no_busy", {30'd0, busy1, busy0}, 32'd0);
    cpu_read_en = 1'b0;

    // Random idle passthrough traffic.
    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom);
      if (ra == DMA_REG) ra = ra ^ 16'h1;
      cpu_addr = ra; cpu_data_in = 8'($urandom);
      cpu_write_en = 1'($urandom); cpu_read_en = 1'($urandom);
      #1;
      chk("pt_addr", {16'd0, ma0}, {16'd0, ra});
      chk("pt_strobes", {30'd0, mwe0, mre0}, {30'd0, cpu_write_en, cpu_read_en});
      chk("pt_wdata", {24'd0, mdi0}, {24'd0, cpu_data_in});
      chk("pt_rdata", {24'd0, cdo0}, {24'd0, mem[ra]});
      tick();
    end
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;

    start_dma(8'h02);
    wait_done();
    check_dma(8'h02);

    for (int k = 0; k < 2; k++) begin
      rpg = 8'($urandom_range(0, 254));
      start_dma(rpg);
      wait_done();
      check_dma(rpg);
    end

    // Top page must stop at 16'hFFFF with no extra write.
    start_dma(8'hFF);
    wait_done();
    check_dma(8'hFF);
    chk("last_rd_rw0", {16'd0, last_rd0}, {16'd0, 16'hFFFF});
    chk("last_rd_rw2", {16'd0, last_rd1}, {16'd0, 16'hFFFF});

    // A second trigger write during the transfer is ignored.
    start_dma(8'h03);
    c = 0;
    while (c < 2000 && q0.size() - qb0 < 10) begin tick(); c++; end
    chk("reach_byte10", {31'd0, c < 2000}, 32'd1);
    cpu_addr = DMA_REG; cpu_data_in = 8'h07; cpu_write_en = 1'b1; cpu_read_en = 1'b1;
    #1;
    chk("busy_cpu_data_zero", {24'd0, cdo0}, 32'd0);
    chk("busy_stall_high", {31'd0, stall0}, 32'd1);
    tick();
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    wait_done();
    check_dma(8'h03);

    // Reset in the middle of a transfer aborts it immediately.
    start_dma(8'h02);
    c = 0;
    while (c < 2000 && q0.size() - qb0 < 100) begin tick(); c++; end
    chk("reach_byte100", {31'd0, c < 2000}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_stall", {30'd0, stall1, stall0}, 32'd0);
    chk("abort_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("abort_done", {30'd0, done1, done0}, 32'd0);
    s0 = q0.size(); s1 = q1.size();
    chk("abort_at_byte100", s0 - qb0, 100);
    repeat (2) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("no_writes_after_abort_rw0", q0.size(), s0);
    chk("no_writes_after_abort_rw2", q1.size(), s1);
    cpu_addr = 16'h2000; cpu_data_in = 8'h5A; cpu_write_en = 1'b1;
    #1;
    chk("post_reset_we", {30'd0, mwe1, mwe0}, 32'd3);
    chk("post_reset_addr", {16'd0, ma0}, {16'd0, 16'h2000});
    chk("post_reset_wdata", {24'd0, mdi0}, {24'd0, 8'h5A});
    tick();
    cpu_write_en = 1'b0;
    chk("post_reset_idle", {30'd0, busy1, busy0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter READ_WAIT, default 0, range 0-3: wait cycles between issuing a DMA read and sampling its data.
REQ-002 SHALL have parameter DMA_REG, default 16'h4014: CPU address that triggers DMA.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cpu_addr  input  16  CPU bus address.
REQ-006 cpu_data_in  input  8  CPU write data.
REQ-007 cpu_write_en  input  1  CPU write strobe.
REQ-008 cpu_read_en  input  1  CPU read strobe.
REQ-009 cpu_data_out  output  8  read data returned to the CPU.
REQ-010 cpu_stall  output  1  CPU must hold its state while high.
REQ-011 mem_addr  output  16  address to the memory controller's CPU port.
REQ-012 mem_data_in  output  8  write data to the memory controller.
REQ-013 mem_write_en  output  1  write strobe to the memory controller.
REQ-014 mem_read_en  output  1  read strobe to the memory controller.
REQ-015 mem_data_out  input  8  read data from the memory controller.
REQ-016 dma_busy  output  1  high while not IDLE.
REQ-017 dma_done  output  1  one-cycle pulse after the last byte is written.

Function
REQ-018 SHALL implement states IDLE, ALIGN, RD, RD_WAIT, WR.
REQ-019 IDLE passthrough, all combinational:
- mem_addr, mem_data_in, mem_write_en, mem_read_en = CPU inputs;
- cpu_data_out = mem_data_out.
REQ-020 In IDLE, cpu_write_en with cpu_addr==DMA_REG SHALL trigger DMA on that edge:
- latch page=cpu_data_in and idx=0;
- go to ALIGN;
- suppress mem_write_en in the trigger cycle.
REQ-021 ALIGN SHALL last exactly 1 cycle, then go to RD.
REQ-022 RD: drive mem_addr={page,idx} and mem_read_en=1 for one cycle. If READ_WAIT==0, go to WR; else go to RD_WAIT.
REQ-023 RD_WAIT:
- hold mem_addr={page,idx}, mem_read_en=0;
- stay READ_WAIT cycles, counted by a 2-bit counter reloaded on entry, then go to WR.
REQ-024 SHALL capture mem_data_out into an 8-bit buffer at the final cycle of RD (READ_WAIT==0) or of RD_WAIT.
REQ-025 WR: drive mem_addr=16'h2004, mem_data_in=buffer, mem_write_en=1 for one cycle. The memory controller auto-increments the sprite RAM address on each write.
REQ-026 From WR, if idx!=8'hFF: increment idx (8-bit) and go to RD; if idx==8'hFF: go to IDLE and assert dma_done for exactly that next cycle.
REQ-027 While not IDLE:
- cpu_stall=1, cpu_data_out=8'h00;
- mem strobes are 0 except in RD/WR as above;
- all CPU inputs ignored, including a further DMA_REG write.
REQ-028 cpu_stall SHALL be registered: high from the cycle after the trigger edge through the last WR cycle; low in the cycle dma_done is high.
REQ-029 Total stall SHALL be 1 + 256*(2+READ_WAIT) cycles (513 with READ_WAIT=0).
REQ-030 page 8'hFF SHALL read addresses 16'hFF00-16'hFFFF without wrap into other pages.
REQ-031 A DMA_REG read (cpu_read_en) SHALL NOT trigger DMA and SHALL pass through.

Reset
REQ-032 rst low SHALL at once force:
- state=IDLE, page=0, idx=0, buffer=0, wait counter=0;
- cpu_stall=0, dma_busy=0, dma_done=0.
REQ-033 Reset mid-transfer SHALL abort without further memory writes; passthrough resumes on rst release.

Verification
- Preload 16'h0200-02FF with i^8'hA5; write 8'h02 to 16'h4014 -> 256 writes to 16'h2004 with data i^8'hA5 in order, stall 513 cycles, one dma_done pulse.
- READ_WAIT=2, same stimulus -> stall 1025 cycles, identical data sequence.
- Write 16'h4014 during busy at byte 10 -> ignored; page unchanged; total count still 256.
- Page 8'hFF -> last read address 16'hFFFF; idx wraps to 0; DMA ends cleanly, no extra write.
- Assert rst at byte 100 -> cpu_stall, dma_busy low immediately; no further 16'h2004 writes; next CPU write to 16'h2000 passes through.
- Idle CPU read of 16'h2002 -> mem_read_en=1, cpu_data_out equals mem_data_out, no stall.
